sbox_scheduler: RTL and testbench

Time-multiplexed SubBytes engine that shares four internal `s_box` lanes (one 32-bit word per cycle) between two requesters. The requesters are the cipher round datapath (full 128-bit state SubBytes) and the AES-256 key expansion (32-bit SubWord). The block sits between the round controller and the key schedule, replacing two full-width substitution units with one arbitrated 32-bit unit. It latches each accepted request, sequences the lanes, and returns results with a one-cycle done pulse.

---
 rtl/sbox_scheduler.sv | 140 ++++++++++++++
 tb/tb_sbox_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_scheduler.sv
// Shared 4-lane AES SubBytes engine arbitrated round-robin between the round state and key SubWord.
// Latency: state done 4 edges after accept, key done 1 edge after accept; acks drop while busy.

module s_box (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 as required.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] p;
    sq = x;
    p  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      p  = gmul(p, sq);
    end
    return p;
  endfunction

  logic [7:0] inv;

  assign inv = gf_inv(a_i);
  assign y_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module sbox_scheduler #(
  parameter bit KEY_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_req,
  input  logic [127:0] st_in,
  output logic         st_ack,
  output logic         st_done,
  output logic [127:0] st_out,
  input  logic         kw_req,
  input  logic [31:0]  kw_in,
  output logic         kw_ack,
  output logic         kw_done,
  output logic [31:0]  kw_out,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, ST_RUN, KW_RUN} state_e;

  state_e         state_q;
  logic [1:0]     cnt_q;
  logic [127:0]   st_op_q;
  logic [31:0]    kw_op_q;
  logic [127:0]   st_out_q;
  logic [31:0]    kw_out_q;
  logic           st_done_q;
  logic           kw_done_q;
  logic           last_kw_q;
  logic           idle;
  logic           gnt_st;
  logic           gnt_kw;
  logic [31:0]    lane_in;
  logic [31:0]    lane_out;

  // last_kw_q starts opposite to the preferred requester so the first contested grant follows KEY_FIRST.
  assign idle   = (state_q == IDLE) && !rst;
  assign gnt_st = idle && st_req && (!kw_req || last_kw_q);
  assign gnt_kw = idle && kw_req && (!st_req || !last_kw_q);

  assign lane_in = (state_q == KW_RUN) ? kw_op_q : st_op_q[{cnt_q, 5'b0} +: 32];

  for (genvar g = 0; g < 4; g++) begin : g_lane
    s_box u_sb (
      .a_i (lane_in[8*g +: 8]),
      .y_o (lane_out[8*g +: 8])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      st_op_q   <= '0;
      kw_op_q   <= '0;
      st_out_q  <= '0;
      kw_out_q  <= '0;
      st_done_q <= 1'b0;
      kw_done_q <= 1'b0;
      last_kw_q <= ~KEY_FIRST;
    end else begin
      st_done_q <= 1'b0;
      kw_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_st) begin
            st_op_q   <= st_in;
            cnt_q     <= 2'd0;
            last_kw_q <= 1'b0;
            state_q   <= ST_RUN;
          end else if (gnt_kw) begin
            kw_op_q   <= kw_in;
            last_kw_q <= 1'b1;
            state_q   <= KW_RUN;
          end
        end
        ST_RUN: begin
          st_out_q[{cnt_q, 5'b0} +: 32] <= lane_out;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_q   <= IDLE;
            st_done_q <= 1'b1;
          end
        end
        KW_RUN: begin
          kw_out_q  <= lane_out;
          kw_done_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign st_ack  = gnt_st;
  assign kw_ack  = gnt_kw;
  assign st_done = st_done_q;
  assign kw_done = kw_done_q;
  assign st_out  = st_out_q;
  assign kw_out  = kw_out_q;
  assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_sbox_scheduler.sv
// Bench for sbox_scheduler: schedule/data model checked every cycle plus directed FIPS-197 vectors.
module tb_sbox_scheduler;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         st_req = 1'b0;
  logic [127:0] st_in = '0;
  logic         kw_req = 1'b0;
  logic [31:0]  kw_in = '0;
  logic         st_ack, st_done, kw_ack, kw_done, busy;
  logic [127:0] st_out;
  logic [31:0]  kw_out;

  always #5 clk = ~clk;

  sbox_scheduler #(.KEY_FIRST(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .st_req  (st_req),
    .st_in   (st_in),
    .st_ack  (st_ack),
    .st_done (st_done),
    .st_out  (st_out),
    .kw_req  (kw_req),
    .kw_in   (kw_in),
    .kw_ack  (kw_ack),
    .kw_done (kw_done),
    .kw_out  (kw_out),
    .busy    (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] sb [256];

  // Reference S-box: brute-force inverse from polynomial multiply mod 0x11b, then the FIPS affine map.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({7'b0, a} << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h011b << (i - 8));
    return p[7:0];
  endfunction

  initial begin
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gf_mul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  end

  function automatic logic [127:0] sub128(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sb[v[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] sub32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sb[v[8*i +: 8]];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h want=%h at %0t", nm, got, exp, $time);
  endtask

  task automatic chkb(input string nm, input logic got, input logic exp);
    chk(nm, {127'b0, got}, {127'b0, exp});
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    chk(nm, {96'b0, got}, {96'b0, exp});
  endtask

  // Schedule model: an accepted op occupies the engine for a fixed number of cycles.
  int           busy_rem = 0;
  int           st_due = -1;
  int           kw_due = -1;
  logic         m_last_kw = 1'b0;
  logic [127:0] st_pend = '0;
  logic [31:0]  kw_pend = '0;
  logic [31:0]  kw_model = '0;

  always @(negedge clk) begin
    logic e_sa, e_ka, e_sd, e_kd, e_busy;
    if (rst) begin
      busy_rem  = 0;
      st_due    = -1;
      kw_due    = -1;
      m_last_kw = 1'b0;
      kw_model  = '0;
      chkb("rst_st_ack", st_ack, 1'b0);
      chkb("rst_kw_ack", kw_ack, 1'b0);
      chkb("rst_st_done", st_done, 1'b0);
      chkb("rst_kw_done", kw_done, 1'b0);
      chkb("rst_busy", busy, 1'b0);
      chk("rst_st_out", st_out, '0);
      chk("rst_kw_out", {96'b0, kw_out}, '0);
    end else begin
      e_sd   = (st_due == 0);
      e_kd   = (kw_due == 0);
      e_busy = (busy_rem > 0);
      e_sa   = 1'b0;
      e_ka   = 1'b0;
      if (!e_busy) begin
        if (st_req && kw_req) begin
          e_sa = m_last_kw;
          e_ka = !m_last_kw;
        end else begin
          e_sa = st_req;
          e_ka = kw_req;
        end
      end
      if (e_kd) kw_model = kw_pend;
      chkb("m_st_ack", st_ack, e_sa);
      chkb("m_kw_ack", kw_ack, e_ka);
      chkb("m_st_done", st_done, e_sd);
      chkb("m_kw_done", kw_done, e_kd);
      chkb("m_busy", busy, e_busy);
      chk("m_kw_out", {96'b0, kw_out}, {96'b0, kw_model});
      if (e_sd) chk("m_st_out", st_out, st_pend);
      if (st_due >= 0) st_due--;
      if (kw_due >= 0) kw_due--;
      if (busy_rem > 0) busy_rem--;
      if (e_sa) begin
        st_pend   = sub128(st_in);
        st_due    = 4;
        busy_rem  = 4;
        m_last_kw = 1'b0;
      end else if (e_ka) begin
        kw_pend   = sub32(kw_in);
        kw_due    = 1;
        busy_rem  = 1;
        m_last_kw = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit is_kw, input int maxc, output int cyc, output int busyc);
    bit hit;
    hit = 1'b0;
    cyc = 0;
    busyc = 0;
    while (!hit && cyc < maxc) begin
      @(negedge clk);
      cyc++;
      if (busy) busyc++;
      hit = is_kw ? kw_done : st_done;
    end
    if (!hit) begin
      n_checks++;
      $display("FAIL done_timeout is_kw=%0d waited=%0d cycles", is_kw, cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bc, nd;
    int sa, ka, sd, kd, both_a, both_d, alt_err, lastt;
    logic [127:0] seq_in;
    seq_in = 128'h000102030405060708090a0b0c0d0e0f;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chkb("reset_busy", busy, 1'b0);
    chk("reset_st_out", st_out, '0);

    // All-zero state
    tick(); st_in = '0; st_req = 1'b1;
    @(negedge clk); chkb("t1_ack", st_ack, 1'b1);
    tick(); st_req = 1'b0;
    wait_done(1'b0, 10, cyc, bc);
    chki("t1_latency", cyc, 5);
    chki("t1_busy_cycles", bc, 4);
    chk("t1_data", st_out, {16{8'h63}});

    // FIPS-197 SubWord
    tick(); kw_in = 32'hcf4f3c09; kw_req = 1'b1;
    @(negedge clk); chkb("t2_ack", kw_ack, 1'b1);
    tick(); kw_req = 1'b0;
    wait_done(1'b1, 10, cyc, bc);
    chki("t2_latency", cyc, 2);
    chk("t2_data", {96'b0, kw_out}, {96'b0, 32'h8a84eb01});

    // Simultaneous requests right after reset, key wins the tie
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    st_in = seq_in; kw_in = 32'h53535353; st_req = 1'b1; kw_req = 1'b1;
    @(negedge clk);
    chkb("t3_kw_first", kw_ack, 1'b1);
    chkb("t3_st_wait", st_ack, 1'b0);
    tick(); kw_req = 1'b0;
    wait_done(1'b1, 10, cyc, bc);
    chk("t3_kw_data", {96'b0, kw_out}, {96'b0, 32'hedededed});
    chkb("t3_st_next", st_ack, 1'b1);
    tick(); st_in = '0; kw_in = 32'h00000000; kw_req = 1'b1;
    wait_done(1'b0, 10, cyc, bc);
    chki("t3_st_latency", cyc, 5);
    chk("t3_st_data", st_out, 128'h637c777bf26b6fc53001672bfed7ab76);
    chkb("t3_rr_kw", kw_ack, 1'b1);
    chkb("t3_rr_st", st_ack, 1'b0);
    tick(); kw_req = 1'b0;
    wait_done(1'b1, 10, cyc, bc);
    chk("t3_kw2_data", {96'b0, kw_out}, {96'b0, 32'h63636363});
    chkb("t3_st_regrant", st_ack, 1'b1);
    tick(); st_req = 1'b0;
    wait_done(1'b0, 10, cyc, bc);
    chk("t3_st2_data", st_out, {16{8'h63}});

    // Operand isolation
    tick(); st_in = {16{8'h53}}; st_req = 1'b1;
    @(negedge clk); chkb("t4_ack", st_ack, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(); st_req = 1'b0;
      st_in = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk);
    chkb("t4_done", st_done, 1'b1);
    chk("t4_data", st_out, {16{8'hed}});

    // Asynchronous reset at cnt==2
    tick(); st_in = 128'hffeeddccbbaa99887766554433221100; st_req = 1'b1;
    @(negedge clk); chkb("t5_ack", st_ack, 1'b1);
    tick(); st_req = 1'b0;
    tick();
    tick(); rst = 1'b1; st_req = 1'b1;
    #1;
    chkb("t5_async_busy", busy, 1'b0);
    chkb("t5_async_ack", st_ack, 1'b0);
    chkb("t5_async_done", st_done, 1'b0);
    chk("t5_async_st_out", st_out, '0);
    chk("t5_async_kw_out", {96'b0, kw_out}, '0);
    tick(); tick(); rst = 1'b0; st_req = 1'b0;
    nd = 0;
    repeat (8) begin @(negedge clk); if (st_done) nd++; end
    chki("t5_no_done", nd, 0);
    tick(); st_in = seq_in; st_req = 1'b1;
    @(negedge clk); chkb("t5_reack", st_ack, 1'b1);
    tick(); st_req = 1'b0;
    wait_done(1'b0, 10, cyc, bc);
    chki("t5_latency", cyc, 5);
    chk("t5_data", st_out, 128'h637c777bf26b6fc53001672bfed7ab76);

    // Sustained contention
    sa = 0; ka = 0; sd = 0; kd = 0; both_a = 0; both_d = 0; alt_err = 0; lastt = -1;
    tick(); st_req = 1'b1; kw_req = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (st_ack && kw_ack) both_a++;
      if (st_done && kw_done) both_d++;
      if (st_ack) begin sa++; if (lastt == 0) alt_err++; lastt = 0; end
      if (kw_ack) begin ka++; if (lastt == 1) alt_err++; lastt = 1; end
      if (st_done) sd++;
      if (kw_done) kd++;
      tick();
      st_in = {$urandom, $urandom, $urandom, $urandom};
      kw_in = $urandom;
    end
    st_req = 1'b0; kw_req = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (st_done && kw_done) both_d++;
      if (st_done) sd++;
      if (kw_done) kd++;
    end
    chki("t6_both_ack", both_a, 0);
    chki("t6_both_done", both_d, 0);
    chki("t6_alternate", alt_err, 0);
    chki("t6_st_done_count", sd, sa);
    chki("t6_kw_done_count", kd, ka);
    chkb("t6_progress", (sa >= 5) && (ka >= 5), 1'b1);
    chkb("t6_idle_end", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
